// File: rtl/q15_div.sv
// Sequential signed Q15 divider (64-bit words, FRAC_BITS fraction bits), restoring
// division producing one quotient bit per cycle, with saturation and valid/ready handshakes.
module q15_div #(
   parameter int FRAC_BITS = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_q,
   output logic        out_overflow,
   output logic        out_div_zero
);

   localparam int          SH    = 63 - FRAC_BITS;
   localparam logic [63:0] Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Q_MIN = 64'h8000_0000_0000_0001;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_next;
   logic        sign;
   logic [63:0] mag_b;
   logic [64:0] rem;
   logic [62:0] quo;
   logic [62:0] shifter;
   logic [5:0]  count;

   logic [63:0]  abs_a, abs_b;
   logic         accept, b_zero, ovf_hit, special;
   logic [63:0]  special_q;
   logic [64:0]  rem_shift, rem_step;
   logic         q_bit;
   logic [62:0]  quo_step;
   logic [63:0]  res_mag, result;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;

   // Operand magnitudes: negating 0x8000... yields 2^63 when read as unsigned.
   assign abs_a   = in_a[63] ? -in_a : in_a;
   assign abs_b   = in_b[63] ? -in_b : in_b;
   assign b_zero  = (in_b == 64'd0);
   assign ovf_hit = ({64'd0, abs_a} >= ({64'd0, abs_b} << SH));
   assign special = b_zero || ovf_hit || (in_a == 64'd0);

   // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      special_q = 64'd0;
      if (b_zero)
         special_q = in_a[63] ? Q_MIN : Q_MAX;
      else if (ovf_hit)
         special_q = (in_a[63] ^ in_b[63]) ? Q_MIN : Q_MAX;
   end

   // One restoring step; the remainder stays below |b| so the dropped top bit is always zero.
   assign rem_shift = 65'({rem, shifter[62]});
   assign q_bit     = (rem_shift >= {1'b0, mag_b});
   assign rem_step  = q_bit ? (rem_shift - {1'b0, mag_b}) : rem_shift;
   assign quo_step  = {quo[61:0], q_bit};
   assign res_mag   = {1'b0, quo_step};
   assign result    = sign ? -res_mag : res_mag;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = special ? DONE : CALC;
         CALC: if (count == 6'd0) state_next = DONE;
         DONE: if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sign         <= 1'b0;
         mag_b        <= 64'd0;
         rem          <= 65'd0;
         quo          <= 63'd0;
         shifter      <= 63'd0;
         count        <= 6'd0;
         out_valid    <= 1'b0;
         out_q        <= 64'd0;
         out_overflow <= 1'b0;
         out_div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign         <= in_a[63] ^ in_b[63];
               mag_b        <= abs_b;
               rem          <= {1'b0, abs_a >> SH};
               shifter      <= {abs_a[SH-1:0], {FRAC_BITS{1'b0}}};
               quo          <= 63'd0;
               count        <= 6'd62;
               out_q        <= special_q;
               out_div_zero <= b_zero;
               out_overflow <= !b_zero && ovf_hit;
            end
            CALC: begin
               rem     <= rem_step;
               quo     <= quo_step;
               shifter <= shifter << 1;
               count   <= count - 6'd1;
               if (count == 6'd0) out_q <= result;
            end
            DONE: begin
               // Result becomes visible one cycle after DONE entry and is held until consumed.
               if (!out_valid)    out_valid <= 1'b1;
               else if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_q15_div.sv
// Self-checking bench for q15_div: directed vectors plus a few random ones,
// with expected results queued at issue and compared when the DUT presents them.
module tb_q15_div;

   localparam logic [63:0] Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Q_MIN = 64'h8000_0000_0000_0001;
   localparam logic [63:0] ONE   = 64'h0001_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_q;
   logic        out_overflow;
   logic        out_div_zero;

   typedef struct {
      logic [63:0] q;
      logic        ovf;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   q15_div dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_q        (out_q),
      .out_overflow (out_overflow),
      .out_div_zero (out_div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] q, input logic ovf, input logic dz, input int lat);
      exp_t e;
      e.q = q; e.ovf = ovf; e.dz = dz; e.lat = lat;
      return e;
   endfunction

   // Reference: exact quotient via 128-bit integer division, truncated toward zero.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
      logic         s;
      logic [127:0] ma, mb, qm;
      s  = a[63] ^ b[63];
      ma = {64'd0, (a[63] ? -a : a)};
      mb = {64'd0, (b[63] ? -b : b)};
      if (b == 64'd0)           return mk(a[63] ? Q_MIN : Q_MAX, 1'b0, 1'b1, 1);
      if (ma >= (mb << 15))     return mk(s ? Q_MIN : Q_MAX, 1'b1, 1'b0, 1);
      if (a == 64'd0)           return mk(64'd0, 1'b0, 1'b0, 1);
      qm = (ma << 48) / mb;
      return mk(s ? -qm[63:0] : qm[63:0], 1'b0, 1'b0, 64);
   endfunction

   // Issue one division, wait for the result, compare it, optionally stall, then retire.
   task automatic do_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input exp_t e, input int hold);
      exp_t got;
      int   n;
      @(negedge clk);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (!out_valid && n < 200);
      check({tag, "_latency"}, 64'(n), 64'(e.lat));
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_q"},   out_q, got.q);
         check({tag, "_ovf"}, 64'(out_overflow), 64'(got.ovf));
         check({tag, "_dz"},  64'(out_div_zero), 64'(got.dz));
      end
      for (int i = 0; i < hold; i++) begin
         if (i == 4) begin
            in_a = 64'h0003_0000_0000_0000; in_b = ONE; in_valid = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_q"},     out_q, e.q);
         check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_retired"},  64'(out_valid), 64'd0);
      check({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic signed [63:0] ra, rb;
      int n;

      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready",  64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_q",     out_q, 64'd0);
      check("rst_ovf",       64'(out_overflow), 64'd0);
      check("rst_dz",        64'(out_div_zero), 64'd0);

      do_div("one_by_two",  ONE, 64'h0002_0000_0000_0000, mk(64'h0000_8000_0000_0000, 0, 0, 64), 0);
      do_div("m3_by_2",     64'hFFFD_0000_0000_0000, 64'h0002_0000_0000_0000,
             mk(64'hFFFE_8000_0000_0000, 0, 0, 64), 0);
      do_div("one_by_3",    ONE, 64'h0003_0000_0000_0000, mk(64'h0000_5555_5555_5555, 0, 0, 64), 0);
      do_div("m1_by_3",     64'hFFFF_0000_0000_0000, 64'h0003_0000_0000_0000,
             mk(64'hFFFF_AAAA_AAAA_AAAB, 0, 0, 64), 0);
      do_div("min_by_m1",   64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0000, mk(Q_MAX, 1, 0, 1), 0);
      do_div("p5_by_0",     64'h0005_0000_0000_0000, 64'd0, mk(Q_MAX, 0, 1, 1), 0);
      do_div("m5_by_0",     64'hFFFB_0000_0000_0000, 64'd0, mk(Q_MIN, 0, 1, 1), 0);
      do_div("ovf_pos",     64'h4000_0000_0000_0000, 64'd1, mk(Q_MAX, 1, 0, 1), 0);
      do_div("ovf_neg",     64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, mk(Q_MIN, 1, 0, 1), 0);
      do_div("zero_by_3",   64'd0, 64'h0003_0000_0000_0000, mk(64'd0, 0, 0, 1), 0);

      for (int i = 0; i < 4; i++) begin
         ra = $signed({$urandom, $urandom}) >>> 20;
         rb = $signed({$urandom, $urandom}) >>> 4;
         do_div("random", ra, rb, model(ra, rb), 0);
      end

      // Backpressure: result held for 10 cycles, a pulsed in_valid meanwhile must be ignored.
      do_div("backpressure", 64'h0007_0000_0000_0000, 64'h0002_0000_0000_0000,
             mk(64'h0003_8000_0000_0000, 0, 0, 64), 10);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_no_ghost_valid", 64'(out_valid), 64'd0);
         check("bp_no_ghost_ready", 64'(in_ready), 64'd1);
      end

      // Reset mid-CALC, with in_valid asserted during the reset cycle.
      @(negedge clk);
      in_a = 64'h0005_0000_0000_0000; in_b = 64'h0003_0000_0000_0000; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("midcalc_busy", 64'(in_ready), 64'd0);
      in_a = ONE; in_b = 64'h0002_0000_0000_0000; in_valid = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      check("midrst_in_ready",  64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_q",     out_q, 64'd0);
      n = 0;
      repeat (70) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) n++;
      end
      check("midrst_no_stale", 64'(n), 64'd0);
      do_div("after_reset", ONE, 64'h0002_0000_0000_0000, mk(64'h0000_8000_0000_0000, 0, 0, 64), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
